pid_output_processor: RTL and testbench
=======================================

PID_OUTPUT_PROCESSOR -- requirements
Module: pid_output_processor

Interface
REQ-001 Parameter DATA_WIDTH, 16, width of PID result word (two's complement).
REQ-002 Parameter NUM_CHN, 4, number of motor channels.
REQ-003 Parameter CHN_WIDTH, 3, width of channel index.
REQ-004 Parameter DUTY_MAX, 1023, saturation limit of duty magnitude.
REQ-005 Parameter PWM_PERIOD, 1024, clk cycles per PWM period; SHALL exceed DUTY_MAX.
REQ-006 Parameter WDT_PERIODS, 50, PWM periods without update before channel is forced off.
REQ-007 clk  input  1  single clock; reset is synchronous and active-low.
REQ-008 rstn  input  1  synchronous active-low reset.
REQ-009 res_valid_o  input  1  PID result strobe, one cycle per result.
REQ-010 res_chn_o  input  CHN_WIDTH  channel of result.
REQ-011 res_data_o  input  DATA_WIDTH  signed PID output; sign = direction, magnitude = duty.
REQ-012 mot_a  output  NUM_CHN  H-bridge forward leg per channel, registered.
REQ-013 mot_b  output  NUM_CHN  H-bridge reverse leg per channel, registered.
REQ-014 wdt_flag  output  NUM_CHN  per-channel watchdog-expired status, registered.

Function
REQ-015 Result with res_valid_o=1 and res_chn_o<NUM_CHN SHALL be written to that channel's shadow register on the same edge; res_chn_o>=NUM_CHN SHALL be ignored.
REQ-016 Shadow magnitude = |res_data_o| saturated to DUTY_MAX; -2^(DATA_WIDTH-1) SHALL saturate to DUTY_MAX; shadow sign = res_data_o[DATA_WIDTH-1].
REQ-017 One shared period counter SHALL count 0..PWM_PERIOD-1 and wrap to 0; the edge at count PWM_PERIOD-1 is the boundary.
REQ-018 Active duty/direction per channel SHALL load from shadow only at the boundary; mid-period shadow writes SHALL not alter the current period.
REQ-019 Valid on the boundary edge: boundary loads the pre-edge shadow; new value takes effect at the following boundary.
REQ-020 Per-channel FSM states IDLE, FWD, REV, DEAD; reset state IDLE.
REQ-021 At boundary: magnitude 0 -> IDLE; nonzero, sign 0 -> FWD; nonzero, sign 1 -> REV; except REQ-022.
REQ-022 At boundary, FWD->REV or REV->FWD request SHALL enter DEAD for exactly one full period (both legs low), then at next boundary apply REQ-021 with current shadow.
REQ-023 IDLE->FWD/REV SHALL not pass through DEAD.
REQ-024 mot_a[i] SHALL register (state==FWD && count<duty_active); mot_b[i] SHALL register (state==REV && count<duty_active); one-cycle latency from counter.
REQ-025 mot_a[i] and mot_b[i] SHALL never both be 1.
REQ-026 Per-channel watchdog SHALL count boundaries since last accepted result for that channel and clear to 0 on every accepted result.
REQ-027 On reaching WDT_PERIODS: shadow magnitude cleared to 0, wdt_flag[i] set; channel reaches IDLE at next boundary.
REQ-028 wdt_flag[i] SHALL clear on the next accepted result for channel i; result and expiry on the same edge -> result wins, flag not set.

Reset
REQ-029 rstn=0 sampled at a clk edge SHALL clear period counter, shadows, active duties, watchdogs, mot_a, mot_b, wdt_flag to 0 and all FSMs to IDLE; takes effect mid-period with no partial pulse after the reset edge.
REQ-030 First boundary after reset release SHALL occur PWM_PERIOD cycles after the first non-reset edge.

Verification (PWM_PERIOD=16, DUTY_MAX=10, WDT_PERIODS=4)
REQ-031 Result ch0 = +6 -> from next period mot_a[0] high 6 of 16 cycles, mot_b[0]=0.
REQ-032 Result ch1 = -32768 -> mot_b[1] high 10 of 16 cycles (saturated), mot_a[1]=0.
REQ-033 ch2 at +5, then -5 -> one full period of both legs low, then mot_b[2] high 5 of 16.
REQ-034 ch3 at +4, no further results -> after 4 boundaries wdt_flag[3]=1, legs low from next period; new result +3 clears flag, 3/16 forward.
REQ-035 Result chn=5 with data +8 -> no output or flag change on any channel.
REQ-036 Result ch0 +8 on boundary edge while shadow holds +2 -> next period 2/16, following period 8/16; rstn=0 mid-period -> all outputs 0 next cycle.

Source files
------------

// File: rtl/pid_output_processor.sv
`default_nettype none
// ============================================================================
// Module   : pid_output_processor
// Purpose  : Turns signed PID results into per-channel H-bridge PWM drive.
//            Each result lands in a shadow register; active duty/direction
//            load from the shadow only at the PWM period boundary. Direction
//            reversals insert one full dead period. A per-channel watchdog
//            forces a channel off when results stop arriving.
// Ports    : clk          - single clock
//            rstn         - synchronous active-low reset
//            res_valid_o  - PID result strobe (one cycle per result)
//            res_chn_o    - channel index of the result
//            res_data_o   - signed result: sign = direction, |value| = duty
//            mot_a        - forward leg per channel (registered)
//            mot_b        - reverse leg per channel (registered)
//            wdt_flag     - watchdog-expired status per channel (registered)
// Revision : 1.0 - initial release
// ============================================================================
module pid_output_processor #(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_CHN     = 4,
    parameter int CHN_WIDTH   = 3,
    parameter int DUTY_MAX    = 1023,
    parameter int PWM_PERIOD  = 1024,
    parameter int WDT_PERIODS = 50
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  res_valid_o,
    input  logic [CHN_WIDTH-1:0]  res_chn_o,
    input  logic [DATA_WIDTH-1:0] res_data_o,
    output logic [NUM_CHN-1:0]    mot_a,
    output logic [NUM_CHN-1:0]    mot_b,
    output logic [NUM_CHN-1:0]    wdt_flag
);

    // Duty never exceeds PWM_PERIOD-1, so the counter width also holds duty.
    localparam int CNT_W = $clog2(PWM_PERIOD);
    localparam int WDT_W = $clog2(WDT_PERIODS + 1);

    localparam logic [CNT_W-1:0]     C_CNT_LAST = CNT_W'(PWM_PERIOD - 1);
    localparam logic [CNT_W-1:0]     C_DUTY_MAX = CNT_W'(DUTY_MAX);
    localparam logic [DATA_WIDTH-1:0] C_DUTY_MAX_W = DATA_WIDTH'(DUTY_MAX);
    localparam logic [CHN_WIDTH:0]   C_NUM_CHN  = (CHN_WIDTH + 1)'(NUM_CHN);
    localparam logic [WDT_W-1:0]     C_WDT_LAST = WDT_W'(WDT_PERIODS - 1);
    localparam logic [WDT_W-1:0]     C_WDT_MAX  = WDT_W'(WDT_PERIODS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_REV  = 2'd2,
        ST_DEAD = 2'd3
    } state_t;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_CHN-1:0]    mot_a_q, mot_a_d;
    logic [NUM_CHN-1:0]    mot_b_q, mot_b_d;
    logic [NUM_CHN-1:0]    wdt_flag_q, wdt_flag_d;

    logic                  w_boundary;
    logic                  w_res_ok;
    logic                  w_res_sgn;
    logic [DATA_WIDTH-1:0] w_res_abs;
    logic [CNT_W-1:0]      w_res_mag;

    assign w_boundary = (cnt_q == C_CNT_LAST);
    assign w_res_ok   = res_valid_o && ({1'b0, res_chn_o} < C_NUM_CHN);
    assign w_res_sgn  = res_data_o[DATA_WIDTH-1];

    // Absolute value taken as unsigned so the most negative input becomes
    // 2^(DATA_WIDTH-1) and saturates like any other large magnitude.
    always_comb begin
        w_res_abs = w_res_sgn ? (~res_data_o + 1'b1) : res_data_o;
        w_res_mag = (w_res_abs > C_DUTY_MAX_W) ? C_DUTY_MAX : w_res_abs[CNT_W-1:0];
    end

    always_comb begin
        cnt_d = w_boundary ? '0 : cnt_q + 1'b1;
    end

    generate
        for (genvar i = 0; i < NUM_CHN; i++) begin : g_chn
            logic             wr;
            logic [CNT_W-1:0] shd_mag_q, shd_mag_d;
            logic             shd_sgn_q, shd_sgn_d;
            logic [CNT_W-1:0] duty_q, duty_d;
            logic [WDT_W-1:0] wdt_q, wdt_d;
            logic             flag_d;
            state_t           state_q, state_d;
            state_t           tgt;

            assign wr = w_res_ok && (res_chn_o == CHN_WIDTH'(i));

            always_comb begin
                shd_mag_d = shd_mag_q;
                shd_sgn_d = shd_sgn_q;
                duty_d    = duty_q;
                wdt_d     = wdt_q;
                flag_d    = wdt_flag_q[i];
                state_d   = state_q;

                if (shd_mag_q == '0) begin
                    tgt = ST_IDLE;
                end else if (shd_sgn_q) begin
                    tgt = ST_REV;
                end else begin
                    tgt = ST_FWD;
                end

                if (w_boundary) begin
                    duty_d = shd_mag_q;
                    case (state_q)
                        ST_FWD:  state_d = (tgt == ST_REV) ? ST_DEAD : tgt;
                        ST_REV:  state_d = (tgt == ST_FWD) ? ST_DEAD : tgt;
                        default: state_d = tgt;
                    endcase
                    // Watchdog saturates at its limit; the expiry action
                    // fires once, on the boundary that reaches the limit.
                    if (wdt_q != C_WDT_MAX) begin
                        wdt_d = wdt_q + 1'b1;
                    end
                    if (wdt_q == C_WDT_LAST) begin
                        shd_mag_d = '0;
                        flag_d    = 1'b1;
                    end
                end

                // An accepted result overrides a same-edge watchdog expiry.
                if (wr) begin
                    shd_mag_d = w_res_mag;
                    shd_sgn_d = w_res_sgn;
                    wdt_d     = '0;
                    flag_d    = 1'b0;
                end
            end

            assign wdt_flag_d[i] = flag_d;
            assign mot_a_d[i]    = (state_q == ST_FWD) && (cnt_q < duty_q);
            assign mot_b_d[i]    = (state_q == ST_REV) && (cnt_q < duty_q);

            always_ff @(posedge clk) begin
                if (!rstn) begin
                    shd_mag_q <= '0;
                    shd_sgn_q <= 1'b0;
                    duty_q    <= '0;
                    wdt_q     <= '0;
                    state_q   <= ST_IDLE;
                end else begin
                    shd_mag_q <= shd_mag_d;
                    shd_sgn_q <= shd_sgn_d;
                    duty_q    <= duty_d;
                    wdt_q     <= wdt_d;
                    state_q   <= state_d;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q      <= '0;
            mot_a_q    <= '0;
            mot_b_q    <= '0;
            wdt_flag_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            mot_a_q    <= mot_a_d;
            mot_b_q    <= mot_b_d;
            wdt_flag_q <= wdt_flag_d;
        end
    end

    assign mot_a    = mot_a_q;
    assign mot_b    = mot_b_q;
    assign wdt_flag = wdt_flag_q;

endmodule
`default_nettype wire

// File: tb/tb_pid_output_processor.sv
`default_nettype none
// ============================================================================
// Module   : tb_pid_output_processor
// Purpose  : Directed self-checking bench for pid_output_processor with a
//            16-cycle PWM period, duty limit 10 and 4-period watchdog.
//            Boundary edges are tracked by the bench from reset release:
//            the N-th non-reset edge is a boundary when N is a multiple of 16.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pid_output_processor;

    localparam int DATA_WIDTH  = 16;
    localparam int NUM_CHN     = 4;
    localparam int CHN_WIDTH   = 3;
    localparam int DUTY_MAX    = 10;
    localparam int PWM_PERIOD  = 16;
    localparam int WDT_PERIODS = 4;

    logic                  clk;
    logic                  rstn;
    logic                  res_valid_o;
    logic [CHN_WIDTH-1:0]  res_chn_o;
    logic [DATA_WIDTH-1:0] res_data_o;
    logic [NUM_CHN-1:0]    mot_a;
    logic [NUM_CHN-1:0]    mot_b;
    logic [NUM_CHN-1:0]    wdt_flag;

    int n_checks;
    int n_fail;
    int ecount;
    int a_hi [NUM_CHN];
    int b_hi [NUM_CHN];
    int overlap;

    pid_output_processor #(
        .DATA_WIDTH  (DATA_WIDTH),
        .NUM_CHN     (NUM_CHN),
        .CHN_WIDTH   (CHN_WIDTH),
        .DUTY_MAX    (DUTY_MAX),
        .PWM_PERIOD  (PWM_PERIOD),
        .WDT_PERIODS (WDT_PERIODS)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .res_valid_o (res_valid_o),
        .res_chn_o   (res_chn_o),
        .res_data_o  (res_data_o),
        .mot_a       (mot_a),
        .mot_b       (mot_b),
        .wdt_flag    (wdt_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Number of non-reset edges since the last reset.
    always @(posedge clk) begin
        ecount <= rstn ? ecount + 1 : 0;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send(input logic [CHN_WIDTH-1:0] ch, input logic [DATA_WIDTH-1:0] d);
        res_valid_o = 1'b1;
        res_chn_o   = ch;
        res_data_o  = d;
        @(negedge clk);
        res_valid_o = 1'b0;
        res_chn_o   = '0;
        res_data_o  = '0;
    endtask

    // Leaves the bench at the negedge right after a boundary edge.
    task automatic goto_boundary();
        int guard;
        guard = 0;
        while (!((ecount % PWM_PERIOD) == 0 && ecount > 0) && guard < 4 * PWM_PERIOD) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 4 * PWM_PERIOD) check_eq("boundary_timeout", ecount % PWM_PERIOD, 0);
    endtask

    // Samples one full PWM period of registered outputs starting just after
    // a boundary edge; ends on the negedge after the next boundary edge.
    task automatic measure();
        for (int c = 0; c < NUM_CHN; c++) begin
            a_hi[c] = 0;
            b_hi[c] = 0;
        end
        overlap = 0;
        for (int k = 0; k < PWM_PERIOD; k++) begin
            @(negedge clk);
            for (int c = 0; c < NUM_CHN; c++) begin
                a_hi[c] += int'(mot_a[c]);
                b_hi[c] += int'(mot_b[c]);
            end
            if ((mot_a & mot_b) != '0) overlap++;
        end
        check_eq("no_leg_overlap", overlap, 0);
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rstn        = 1'b0;
        res_valid_o = 1'b0;
        res_chn_o   = '0;
        res_data_o  = '0;

        repeat (3) @(negedge clk);
        check_eq("reset_mot_a", int'(mot_a), 0);
        check_eq("reset_mot_b", int'(mot_b), 0);
        check_eq("reset_wdt_flag", int'(wdt_flag), 0);
        rstn = 1'b1;

        // Out-of-range channel is ignored.
        repeat (3) @(negedge clk);
        send(3'd5, 16'd8);
        goto_boundary();
        measure();
        check_eq("bad_chn_a_total", a_hi[0] + a_hi[1] + a_hi[2] + a_hi[3], 0);
        check_eq("bad_chn_b_total", b_hi[0] + b_hi[1] + b_hi[2] + b_hi[3], 0);
        check_eq("bad_chn_wdt_flag", int'(wdt_flag), 0);

        // Edge 32: program all four channels.
        send(3'd0, 16'd6);
        send(3'd1, 16'h8000);
        send(3'd2, 16'd5);
        send(3'd3, 16'd4);
        goto_boundary();
        measure();
        check_eq("ch0_fwd6_a", a_hi[0], 6);
        check_eq("ch0_fwd6_b", b_hi[0], 0);
        check_eq("ch1_sat_b", b_hi[1], 10);
        check_eq("ch1_sat_a", a_hi[1], 0);
        check_eq("ch2_fwd5_a", a_hi[2], 5);
        check_eq("ch3_fwd4_a", a_hi[3], 4);

        // Edge 64: reverse ch2, refresh ch0/ch1, leave ch3 alone.
        send(3'd2, 16'hFFFB);
        send(3'd0, 16'd6);
        send(3'd1, 16'h8000);
        goto_boundary();
        measure();
        check_eq("ch2_dead_a", a_hi[2], 0);
        check_eq("ch2_dead_b", b_hi[2], 0);
        check_eq("ch3_still_a", a_hi[3], 4);
        check_eq("ch0_refresh_a", a_hi[0], 6);
        measure();
        check_eq("ch2_rev5_b", b_hi[2], 5);
        check_eq("ch2_rev5_a", a_hi[2], 0);
        check_eq("ch3_last_period_a", a_hi[3], 4);
        check_eq("ch3_wdt_set", int'(wdt_flag[3]), 1);
        measure();
        check_eq("ch3_off_a", a_hi[3], 0);
        check_eq("ch3_off_b", b_hi[3], 0);
        check_eq("ch3_wdt_held", int'(wdt_flag[3]), 1);

        // Edge 128: new result clears the flag immediately.
        send(3'd3, 16'd3);
        check_eq("ch3_wdt_cleared", int'(wdt_flag[3]), 0);
        goto_boundary();
        measure();
        check_eq("ch3_fwd3_a", a_hi[3], 3);
        check_eq("ch3_fwd3_b", b_hi[3], 0);

        // Edge 160: ch0 shadow +2, then +8 on the boundary edge 176.
        send(3'd0, 16'd2);
        begin
            int guard;
            guard = 0;
            while ((ecount % PWM_PERIOD) != PWM_PERIOD - 1 && guard < 2 * PWM_PERIOD) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 2 * PWM_PERIOD) check_eq("pre_boundary_timeout", ecount % PWM_PERIOD, PWM_PERIOD - 1);
        end
        send(3'd0, 16'd8);
        measure();
        check_eq("ch0_boundary_old_a", a_hi[0], 2);
        measure();
        check_eq("ch0_boundary_new_a", a_hi[0], 8);

        // Reset in the middle of an active pulse.
        @(negedge clk);
        check_eq("ch0_pulse_before_rst", int'(mot_a[0]), 1);
        rstn = 1'b0;
        @(negedge clk);
        check_eq("midrst_mot_a", int'(mot_a), 0);
        check_eq("midrst_mot_b", int'(mot_b), 0);
        check_eq("midrst_wdt_flag", int'(wdt_flag), 0);
        rstn = 1'b1;
        goto_boundary();
        measure();
        check_eq("post_rst_a_total", a_hi[0] + a_hi[1] + a_hi[2] + a_hi[3], 0);
        check_eq("post_rst_b_total", b_hi[0] + b_hi[1] + b_hi[2] + b_hi[3], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
